// File: rtl/effective_address_unit_if.sv
// rtl/effective_address_unit_if.sv - request/result bundle between sequencer and effective address unit
interface effective_address_unit_if #(
    parameter int DATA_W = 8
);
    logic                  start;
    logic [2:0]            mode;
    logic                  force_fix;
    logic [DATA_W-1:0]     address_low;
    logic [DATA_W-1:0]     address_high;
    logic [DATA_W-1:0]     x_reg;
    logic [DATA_W-1:0]     y_reg;
    logic                  busy;
    logic                  dummy_cycle;
    logic [2*DATA_W-1:0]   bus_addr;
    logic [2*DATA_W-1:0]   ea;
    logic                  ea_valid;
    logic                  page_cross;

    modport master (
        output start, mode, force_fix, address_low, address_high, x_reg, y_reg,
        input  busy, dummy_cycle, bus_addr, ea, ea_valid, page_cross
    );

    modport slave (
        input  start, mode, force_fix, address_low, address_high, x_reg, y_reg,
        output busy, dummy_cycle, bus_addr, ea, ea_valid, page_cross
    );
endinterface

// File: rtl/effective_address_unit.sv
// rtl/effective_address_unit.sv - indexed effective address formation with 65C02 page-cross fixup cycle
module effective_address_unit #(
    parameter int DATA_W = 8
) (
    input  logic                 fclk,
    input  logic                 reset,
    effective_address_unit_if.slave eau
);
    localparam int AW = 2 * DATA_W;

    localparam logic [2:0] M_ABSX = 3'd1;
    localparam logic [2:0] M_ABSY = 3'd2;
    localparam logic [2:0] M_ZP   = 3'd3;
    localparam logic [2:0] M_ZPX  = 3'd4;
    localparam logic [2:0] M_ZPY  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_FIX, S_DONE} state_t;

    state_t              state;
    logic [2:0]          op_mode;
    logic                op_force;
    logic [DATA_W-1:0]   op_low;
    logic [DATA_W-1:0]   op_high;
    logic [DATA_W-1:0]   op_index;

    logic                busy_q;
    logic                dummy_q;
    logic                valid_q;
    logic                cross_q;
    logic [AW-1:0]       bus_addr_q;
    logic [AW-1:0]       ea_q;

    logic [DATA_W:0]     low_sum;
    logic                carry;
    logic                abs_indexed;
    logic                zero_page;
    logic [DATA_W-1:0]   start_index;
    logic [AW-1:0]       uncorrected;
    logic [DATA_W-1:0]   high_fixed;

    // Operands stay registered through FIX, so the low-byte sum is simply recomputed there.
    always_comb begin
        low_sum     = {1'b0, op_low} + {1'b0, op_index};
        carry       = low_sum[DATA_W];
        abs_indexed = (op_mode == M_ABSX) || (op_mode == M_ABSY);
        zero_page   = (op_mode == M_ZP) || (op_mode == M_ZPX) || (op_mode == M_ZPY);
        uncorrected = {op_high, low_sum[DATA_W-1:0]};
        high_fixed  = op_high + {{(DATA_W-1){1'b0}}, carry};
    end

    always_comb begin
        start_index = '0;
        case (eau.mode)
            M_ABSX, M_ZPX: start_index = eau.x_reg;
            M_ABSY, M_ZPY: start_index = eau.y_reg;
            default:       start_index = '0;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (reset) begin
            state      <= S_IDLE;
            op_mode    <= '0;
            op_force   <= 1'b0;
            op_low     <= '0;
            op_high    <= '0;
            op_index   <= '0;
            busy_q     <= 1'b0;
            dummy_q    <= 1'b0;
            valid_q    <= 1'b0;
            cross_q    <= 1'b0;
            bus_addr_q <= '0;
            ea_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (eau.start) begin
                        op_mode  <= eau.mode;
                        op_force <= eau.force_fix;
                        op_low   <= eau.address_low;
                        op_high  <= eau.address_high;
                        op_index <= start_index;
                        cross_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= S_ADD;
                    end
                end
                S_ADD: begin
                    if (zero_page) begin
                        ea_q       <= {{DATA_W{1'b0}}, low_sum[DATA_W-1:0]};
                        bus_addr_q <= {{DATA_W{1'b0}}, low_sum[DATA_W-1:0]};
                        valid_q    <= 1'b1;
                        state      <= S_DONE;
                    end else if (abs_indexed) begin
                        cross_q <= carry;
                        if (carry || op_force) begin
                            dummy_q    <= 1'b1;
                            bus_addr_q <= uncorrected;
                            state      <= S_FIX;
                        end else begin
                            ea_q       <= uncorrected;
                            bus_addr_q <= uncorrected;
                            valid_q    <= 1'b1;
                            state      <= S_DONE;
                        end
                    end else begin
                        ea_q       <= {op_high, op_low};
                        bus_addr_q <= {op_high, op_low};
                        valid_q    <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_FIX: begin
                    ea_q       <= {high_fixed, low_sum[DATA_W-1:0]};
                    bus_addr_q <= {high_fixed, low_sum[DATA_W-1:0]};
                    dummy_q    <= 1'b0;
                    valid_q    <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign eau.busy        = busy_q;
    assign eau.dummy_cycle = dummy_q;
    assign eau.bus_addr    = bus_addr_q;
    assign eau.ea          = ea_q;
    assign eau.ea_valid    = valid_q;
    assign eau.page_cross  = cross_q;
endmodule
